// File: rtl/mult_pipe_latch.sv
// mult_pipe_latch: fixed-depth result pipeline for a multi-cycle unit.
// Each slot carries valid/data/addr/we/instr/pc. Supports stall (hold),
// kill (synchronous flush), RAW hazard detection against in-flight
// writers and an occupancy count. Invalid slots always hold zero payload.
module mult_pipe_latch #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int STAGES = 4
) (
    input  logic              clk_i,
    input  logic              rsn_i,
    input  logic              kill_i,
    input  logic              stall_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [ADDR_W-1:0] in_addr_i,
    input  logic              in_we_i,
    input  logic [31:0]       in_instr_i,
    input  logic [31:0]       in_pc_i,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [ADDR_W-1:0] out_addr_o,
    output logic              out_we_o,
    output logic [31:0]       out_instr_o,
    output logic [31:0]       out_pc_o,
    input  logic [ADDR_W-1:0] rs1_addr_i,
    input  logic [ADDR_W-1:0] rs2_addr_i,
    output logic              hazard_o,
    output logic [3:0]        occ_o
);

    logic              valid_r [STAGES];
    logic [DATA_W-1:0] data_r  [STAGES];
    logic [ADDR_W-1:0] addr_r  [STAGES];
    logic              we_r    [STAGES];
    logic [31:0]       instr_r [STAGES];
    logic [31:0]       pc_r    [STAGES];

    logic              hazard_s;
    logic [3:0]        occ_s;

    // Slot registers: async clear, kill flush, otherwise advance unless stalled.
    always_ff @(posedge clk_i or posedge rsn_i) begin
        if (rsn_i) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_r[k] <= 1'b0;
                data_r[k]  <= '0;
                addr_r[k]  <= '0;
                we_r[k]    <= 1'b0;
                instr_r[k] <= 32'h0000_0000;
                pc_r[k]    <= 32'h0000_0000;
            end
        end else if (kill_i) begin
            // Kill wins over stall and over a new entry.
            for (int k = 0; k < STAGES; k++) begin
                valid_r[k] <= 1'b0;
                data_r[k]  <= '0;
                addr_r[k]  <= '0;
                we_r[k]    <= 1'b0;
                instr_r[k] <= 32'h0000_0000;
                pc_r[k]    <= 32'h0000_0000;
            end
        end else if (!stall_i) begin
            for (int k = 1; k < STAGES; k++) begin
                valid_r[k] <= valid_r[k-1];
                data_r[k]  <= data_r[k-1];
                addr_r[k]  <= addr_r[k-1];
                we_r[k]    <= we_r[k-1];
                instr_r[k] <= instr_r[k-1];
                pc_r[k]    <= pc_r[k-1];
            end
            // A bubble enters as all-zero so invalid slots never leak payload.
            if (in_valid_i) begin
                valid_r[0] <= 1'b1;
                data_r[0]  <= in_data_i;
                addr_r[0]  <= in_addr_i;
                we_r[0]    <= in_we_i;
                instr_r[0] <= in_instr_i;
                pc_r[0]    <= in_pc_i;
            end else begin
                valid_r[0] <= 1'b0;
                data_r[0]  <= '0;
                addr_r[0]  <= '0;
                we_r[0]    <= 1'b0;
                instr_r[0] <= 32'h0000_0000;
                pc_r[0]    <= 32'h0000_0000;
            end
        end else begin
            // Stalled: every slot holds its value.
            for (int k = 0; k < STAGES; k++) begin
                valid_r[k] <= valid_r[k];
                data_r[k]  <= data_r[k];
                addr_r[k]  <= addr_r[k];
                we_r[k]    <= we_r[k];
                instr_r[k] <= instr_r[k];
                pc_r[k]    <= pc_r[k];
            end
        end
    end

    // RAW hazard: any valid writer to a non-zero register matching a source.
    always_comb begin
        hazard_s = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            if (valid_r[k] && we_r[k] && (addr_r[k] != '0) &&
                ((addr_r[k] == rs1_addr_i) || (addr_r[k] == rs2_addr_i))) begin
                hazard_s = 1'b1;
            end else begin
                hazard_s = hazard_s;
            end
        end
    end

    // Occupancy: population count of valid slots.
    always_comb begin
        occ_s = 4'd0;
        for (int k = 0; k < STAGES; k++) begin
            occ_s = occ_s + {3'b000, valid_r[k]};
        end
    end

    assign out_valid_o = valid_r[STAGES-1];
    assign out_data_o  = data_r[STAGES-1];
    assign out_addr_o  = addr_r[STAGES-1];
    assign out_we_o    = valid_r[STAGES-1] & we_r[STAGES-1];
    assign out_instr_o = instr_r[STAGES-1];
    assign out_pc_o    = pc_r[STAGES-1];
    assign hazard_o    = hazard_s;
    assign occ_o       = occ_s;

endmodule

// File: doc/mult_pipe_latch.md
MULT_PIPE_LATCH -- requirements
Module: mult_pipe_latch

Interface
REQ-001 SHALL have parameter DATA_W, default 32, result/payload data width.
REQ-002 SHALL have parameter ADDR_W, default 5, register-file write address width.
REQ-003 SHALL have parameter STAGES, default 4, pipeline depth (legal range 2..8).
REQ-004 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rsn_i  input  1  reset, asynchronous, active-high (asserted = 1).
REQ-006 SHALL have port kill_i  input  1  synchronous flush of all stages.
REQ-007 SHALL have port stall_i  input  1  freeze all stages.
REQ-008 SHALL have port in_valid_i  input  1  stage-0 entry valid.
REQ-009 SHALL have port in_data_i  input  DATA_W  entry write data.
REQ-010 SHALL have port in_addr_i  input  ADDR_W  entry write address.
REQ-011 SHALL have port in_we_i  input  1  entry integer write enable.
REQ-012 SHALL have port in_instr_i  input  32  entry instruction word.
REQ-013 SHALL have port in_pc_i  input  32  entry PC.
REQ-014 SHALL have ports out_valid_o/out_data_o/out_addr_o/out_we_o/out_instr_o/out_pc_o  output  1/DATA_W/ADDR_W/1/32/32  last-stage contents.
REQ-015 SHALL have port rs1_addr_i, rs2_addr_i  input  ADDR_W each  hazard query addresses.
REQ-016 SHALL have port hazard_o  output  1  RAW hazard against any in-flight stage.
REQ-017 SHALL have port occ_o  output  4  count of valid stages.

Function
REQ-018 SHALL implement STAGES register slots S0..S(STAGES-1), each holding valid, data, addr, we, instr, pc.
REQ-019 SHALL, per clock edge with kill_i=0 and stall_i=0, load S0 from in_* and S(k) from S(k-1); latency in to out = STAGES cycles.
REQ-020 SHALL, with stall_i=1 and kill_i=0, hold every slot unchanged; in_* ignored that cycle.
REQ-021 SHALL, with kill_i=1, clear every slot to all-zero (valid=0) regardless of stall_i; kill wins over stall and over in_valid_i.
REQ-022 SHALL load S0 as all-zero (valid=0, we=0, payload 0) when in_valid_i=0; invalid slots always carry zero payload.
REQ-023 SHALL drive out_* combinationally from S(STAGES-1) only; out_we_o = valid AND we of that slot.
REQ-024 SHALL assert hazard_o when, for any slot k, valid=1, we=1, addr != 0, and addr equals rs1_addr_i or rs2_addr_i; address 0 never hazards.
REQ-025 SHALL compute hazard_o combinationally from current slot state (not including in_* entry).
REQ-026 SHALL drive occ_o = number of slots with valid=1, range 0..STAGES, zero-extended to 4 bits.
REQ-027 SHALL accept back-to-back valid entries every unstalled cycle with no bubbles inserted.
REQ-028 SHALL not restrict stall_i and kill_i asserted together; REQ-021 applies.

Reset
REQ-029 SHALL, while rsn_i=1, immediately (no clock needed) clear all slots: out_valid_o=0, out_we_o=0, out_data_o=0, out_addr_o=0, out_instr_o=0, out_pc_o=0, hazard_o=0, occ_o=0.
REQ-030 SHALL resume normal operation on the first rising edge after rsn_i deasserts; reset asserted mid-stream discards all in-flight entries.

Verification
REQ-031 Single entry: STAGES=4, in_valid_i=1 once with data=0x12345678, addr=7, we=1, pc=0x100 -> out_valid_o=1 with same values exactly 4 edges later, for one cycle; occ_o 1 during cycles 1..4.
REQ-032 Stall: stream entries A,B,C; stall_i=1 for 3 cycles after B enters -> all slots frozen, out_* unchanged, occ_o constant; on release order A,B,C preserved, no loss or duplication.
REQ-033 Kill: 4 valid entries in flight, kill_i=1 with stall_i=1 and in_valid_i=1 -> next edge occ_o=0, out_valid_o=0, all out_* zero.
REQ-034 Hazard: slot with addr=5, we=1 in flight, rs1_addr_i=5 -> hazard_o=1; same with addr=0 and rs2_addr_i=0 -> hazard_o=0; we=0 with matching addr -> hazard_o=0.
REQ-035 Async reset: assert rsn_i between clock edges with 3 entries in flight -> outputs zero before next edge; after release first new entry exits 4 edges later.
REQ-036 Throughput: in_valid_i=1 for 10 consecutive cycles, STAGES=2 -> out_valid_o=1 for 10 consecutive cycles starting 2 edges later, occ_o=2 in steady state.
